// File: rtl/bnn_neuron_scheduler.sv
// bnn_neuron_scheduler
// Evaluates the 20 neurons of the 8-8-4 binary network (L1: 0-7, L2: 8-15,
// L3: 16-19) one per enabled clock on a single XNOR-popcount-threshold
// engine. Weights and thresholds arrive combinationally from the external
// bank for the registered address w_addr. A run is a start/busy/done
// transaction. result and l2_hi change only on the completion edge.
module bnn_neuron_scheduler #(
  parameter int N_L1 = 8,
  parameter int N_L2 = 8,
  parameter int N_L3 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                start,
  input  logic [N_L1-1:0]     in_vec,
  output logic [4:0]          w_addr,
  input  logic [N_L1-1:0]     w_data,
  input  logic [3:0]          t_data,
  output logic                busy,
  output logic                done,
  output logic [N_L3-1:0]     result,
  output logic [3:0]          l2_hi
);

  // The shared engine's operand width. L2 and L3 consume buffers of this width.
  localparam int XW = N_L1;
  // Width of the popcount sum, 0..XW.
  localparam int SW = $clog2(XW + 1);
  // Width of the local counter. It must span the widest layer.
  localparam int IW = $clog2(N_L1);
  // Width of the global neuron index.
  localparam int AW = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_L1,
    ST_L2,
    ST_L3
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic [AW-1:0]     r_addr;
  logic [XW-1:0]     r_x;
  logic [XW-1:0]     r_l1;
  logic [XW-1:0]     r_l2;
  logic [N_L3-1:0]   r_l3;
  logic              r_busy;
  logic              r_done;
  logic [N_L3-1:0]   r_result;
  logic [3:0]        r_l2_hi;

  logic [XW-1:0]     w_x;
  logic [XW-1:0]     w_dst;
  logic [XW-1:0]     w_mask;
  logic [XW-1:0]     w_dst_next;
  logic [SW-1:0]     w_sum;
  logic              w_fire;
  logic              w_last;

  // Count of ones in an operand. XNOR matches are the ones in ~(x ^ w).
  function automatic logic [SW-1:0] popcount(input logic [XW-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < XW; i++) begin
      c = c + SW'(v[i]);
    end
    return c;
  endfunction

  // Unsigned compare on widened operands, so thresholds above XW never fire.
  function automatic logic fires(input logic [SW-1:0] sum, input logic [3:0] thr);
    return (32'(sum) >= 32'(thr));
  endfunction

  // Select the engine operand, the buffer being filled and the end-of-layer flag.
  always_comb begin
    w_x    = r_x;
    w_dst  = r_l1;
    w_last = 1'b0;
    case (r_state)
      ST_L1: begin
        w_x    = r_x;
        w_dst  = r_l1;
        w_last = (r_idx == IW'(N_L1 - 1));
      end
      ST_L2: begin
        w_x    = r_l1;
        w_dst  = r_l2;
        w_last = (r_idx == IW'(N_L2 - 1));
      end
      ST_L3: begin
        w_x    = r_l2;
        w_dst  = XW'(r_l3);
        w_last = (r_idx == IW'(N_L3 - 1));
      end
      default: begin
        w_x    = r_x;
        w_dst  = r_l1;
        w_last = 1'b0;
      end
    endcase
  end

  // One neuron evaluation, with fire merged into bit idx of the destination buffer.
  always_comb begin
    w_sum      = popcount(~(w_x ^ w_data));
    w_fire     = fires(w_sum, t_data);
    w_mask     = XW'(1) << r_idx;
    w_dst_next = (w_dst & ~w_mask) | (w_mask & {XW{w_fire}});
  end

  // Sequencer. Every enabled cycle in a layer state evaluates one neuron.
  // Addresses run 0..19 because the layer bases are contiguous.
  // done is a one-edge pulse and clears even when ena is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_addr   <= '0;
      r_x      <= '0;
      r_l1     <= '0;
      r_l2     <= '0;
      r_l3     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_l2_hi  <= '0;
    end else begin
      r_done <= 1'b0;
      if (ena) begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_x     <= in_vec;
              r_idx   <= '0;
              r_addr  <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_L1;
            end
          end
          ST_L1: begin
            r_l1   <= w_dst_next;
            r_addr <= r_addr + AW'(1);
            if (w_last) begin
              r_idx   <= '0;
              r_state <= ST_L2;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
          ST_L2: begin
            r_l2   <= w_dst_next;
            r_addr <= r_addr + AW'(1);
            if (w_last) begin
              r_idx   <= '0;
              r_state <= ST_L3;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
          ST_L3: begin
            r_l3 <= w_dst_next[N_L3-1:0];
            if (w_last) begin
              r_idx    <= '0;
              r_addr   <= '0;
              r_result <= w_dst_next[N_L3-1:0];
              r_l2_hi  <= r_l2[XW-1:XW-4];
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_idx  <= r_idx + IW'(1);
              r_addr <= r_addr + AW'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign w_addr = r_addr;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign l2_hi  = r_l2_hi;

endmodule

// File: tb/tb_bnn_neuron_scheduler.sv
// Bench for bnn_neuron_scheduler. The stimulus issues runs and queues the
// reference outcome computed from the network rules. A monitor pops and
// compares the queued outcome on every done pulse.
module tb_bnn_neuron_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       start;
  logic [7:0] in_vec;
  logic [4:0] w_addr;
  logic [7:0] w_data;
  logic [3:0] t_data;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [3:0] l2_hi;

  logic [7:0] W [20];
  logic [3:0] T [20];

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_e;

  bnn_neuron_scheduler #(.N_L1(8), .N_L2(8), .N_L3(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .start  (start),
    .in_vec (in_vec),
    .w_addr (w_addr),
    .w_data (w_data),
    .t_data (t_data),
    .busy   (busy),
    .done   (done),
    .result (result),
    .l2_hi  (l2_hi)
  );

  always #5 clk = ~clk;

  // Weight/threshold bank, combinational read.
  always_comb begin
    w_data = 8'h00;
    t_data = 4'h0;
    if (w_addr < 5'd20) begin
      w_data = W[w_addr];
      t_data = T[w_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference network: three layers, each neuron fires when its XNOR-match count reaches its threshold.
  function automatic logic [7:0] ref_run(input logic [7:0] x);
    logic [7:0] l1, l2;
    logic [3:0] l3;
    for (int n = 0; n < 8; n++) l1[n] = ($countones(~(x  ^ W[n]))      >= int'(T[n]));
    for (int n = 0; n < 8; n++) l2[n] = ($countones(~(l1 ^ W[8 + n]))  >= int'(T[8 + n]));
    for (int n = 0; n < 4; n++) l3[n] = ($countones(~(l2 ^ W[16 + n])) >= int'(T[16 + n]));
    return {l2[7:4], l3};
  endfunction

  task automatic fill_bank(input logic [7:0] wv, input logic [3:0] tv);
    for (int i = 0; i < 20; i++) begin
      W[i] = wv;
      T[i] = tv;
    end
  endtask

  // Monitor: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty queue, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 32'(result), 32'(mon_e[3:0]));
        check("l2_hi", 32'(l2_hi), 32'(mon_e[7:4]));
      end
    end
  end

  // A reset discards the run in flight, along with its expectation.
  always @(posedge reset) exp_q.delete();

  // Issue one run from an idle negedge and time it. On return the bench is at the negedge where done is high.
  task automatic run_one(input logic [7:0] v, input bit chk_addr);
    int  cyc;
    int  busy_cnt;
    bit  got;
    start  = 1'b1;
    in_vec = v;
    @(posedge clk);
    exp_q.push_back(ref_run(v));
    #1 start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        if (chk_addr) check("w_addr_step", 32'(w_addr), 32'(busy_cnt));
        busy_cnt++;
      end
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'(0), 32'(1));
    check("done_edge", 32'(cyc - 1), 32'(20));
    check("busy_cycles", 32'(busy_cnt), 32'(20));
  endtask

  task automatic load_default();
    logic [7:0] d [20];
    d = '{8'h7B, 8'h8B, 8'hD1, 8'h00, 8'h14, 8'h4D, 8'h8F, 8'h03,
          8'hE1, 8'h97, 8'hE1, 8'hB5, 8'h44, 8'h9B, 8'h8E, 8'h58,
          8'hDF, 8'h47, 8'hD6, 8'h42};
    for (int i = 0; i < 20; i++) begin
      W[i] = d[i];
      T[i] = 4'd4;
    end
  endtask

  initial begin
    int  dn [$];
    bit  got;
    reset  = 1'b1;
    ena    = 1'b1;
    start  = 1'b0;
    in_vec = 8'h00;
    fill_bank(8'h00, 4'h0);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_l2_hi", 32'(l2_hi), 32'(0));
    check("rst_w_addr", 32'(w_addr), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // All zero weights and thresholds: every neuron fires.
    run_one(8'h5A, 1'b0);
    check("zero_result", 32'(result), 32'hF);

    // All-ones weights with threshold 8 need an exact match.
    fill_bank(8'hFF, 4'd8);
    run_one(8'hFF, 1'b0);
    run_one(8'hFE, 1'b0);
    check("ones_fe_result", 32'(result), 32'h0);

    // Default weight set with address stepping checked.
    load_default();
    run_one(8'h00, 1'b1);
    check("dflt_result", 32'(result), 32'hA);
    check("dflt_l2_hi", 32'(l2_hi), 32'h6);

    // start held high: accepted only when idle.
    exp_q.push_back(ref_run(8'h3C));
    exp_q.push_back(ref_run(8'h3C));
    start  = 1'b1;
    in_vec = 8'h3C;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) dn.push_back(c - 1);
      if (c == 22) check("held_reaccept_busy", 32'(busy), 32'(1));
      if (c == 42) start = 1'b0;
    end
    check("held_done_count", 32'(dn.size()), 32'(2));
    check("held_done_first", (dn.size() > 0) ? 32'(dn[0]) : 32'hFFFF_FFFF, 32'(20));
    check("held_done_second", (dn.size() > 1) ? 32'(dn[1]) : 32'hFFFF_FFFF, 32'(41));
    check("held_idle", 32'(busy), 32'(0));

    // Three ena-low cycles in L2 stretch the run by three edges.
    start  = 1'b1;
    in_vec = 8'h00;
    @(posedge clk);
    exp_q.push_back(ref_run(8'h00));
    #1 start = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (c == 10) ena = 1'b0;
      if (c == 13) begin
        check("stall_addr_frozen", 32'(w_addr), 32'(9));
        check("stall_busy", 32'(busy), 32'(1));
        ena = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        check("stall_done_edge", 32'(c - 1), 32'(23));
      end
    end
    if (!got) check("stall_timeout", 32'(0), 32'(1));
    check("stall_result", 32'(result), 32'hA);

    // A reset pulsed mid-run clears everything asynchronously.
    @(negedge clk);
    start  = 1'b1;
    in_vec = 8'hC3;
    @(posedge clk);
    exp_q.push_back(ref_run(8'hC3));
    #1 start = 1'b0;
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_l2_hi", 32'(l2_hi), 32'(0));
    check("midrst_w_addr", 32'(w_addr), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_one(8'h00, 1'b1);
    check("post_rst_result", 32'(result), 32'hA);

    // Randomised banks, thresholds and inputs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 20; i++) begin
        W[i] = 8'($urandom);
        T[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 6));
      end
      run_one(8'($urandom), 1'b0);
    end

    // Out-of-range L3 thresholds never fire. Threshold 0 always fires.
    fill_bank(8'h00, 4'h0);
    for (int i = 16; i < 20; i++) T[i] = 4'd9;
    for (int r = 0; r < 3; r++) begin
      run_one(8'($urandom), 1'b0);
      check("l3_thr9_result", 32'(result), 32'h0);
    end
    for (int i = 16; i < 20; i++) T[i] = 4'd0;
    run_one(8'($urandom), 1'b0);
    check("l3_thr0_result", 32'(result), 32'hF);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_neuron_scheduler.md
# bnn_neuron_scheduler

Time-multiplexed sequencer for the 8-8-4 binary neural network. It evaluates all 20 neurons (L1: 0-7, L2: 8-15, L3: 16-19) on one shared XNOR-popcount-threshold engine, one neuron per clock. Weights and thresholds are read from the existing neuron weight/threshold bank through a read port. It sits between the top-level pins and that bank and replaces the three fully parallel combinational layers with a start/busy/done transaction.

## Interface
Parameters:
- `N_L1`, default 8: neurons in layer 1, equal to the input width.
- `N_L2`, default 8: neurons in layer 2.
- `N_L3`, default 4: neurons in layer 3, equal to the result width.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `ena`  in  1: clock-enable. When low, all state holds.
- `start`  in  1: request inference. Sampled only in IDLE with `ena`=1.
- `in_vec`  in  8: input activation vector. Captured on the accepting edge.
- `w_addr`  out  5: global neuron index presented to the bank.
- `w_data`  in  8: weight byte for `w_addr`, combinational same-cycle return.
- `t_data`  in  4: threshold for `w_addr`, combinational same-cycle return.
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  4: L3 outputs. Bit n is L3 neuron n.
- `l2_hi`  out  4: L2 outputs bits [7:4], for debug.

## Operation
- States:
  - IDLE → L1 → L2 → L3 → IDLE.
  - Local counter `idx` counts neurons within the current layer.
  - `w_addr` = layer base + `idx`. Bases are 0, 8 and 16.
- IDLE:
  - Taken if `start` & `ena`: capture `in_vec` into `x_reg`, set `idx`=0, set `busy`=1, go to L1.
  - `start` seen in any other state is ignored and is not queued.
- Evaluate one neuron per enabled cycle:
  - sum = popcount(~(X ^ `w_data`)). sum is 4 bits, range 0..8.
  - fire = (sum >= `t_data`), unsigned compare.
  - X is `x_reg` in L1, the L1 buffer `l1` in L2, and the L2 buffer `l2` in L3.
  - fire is written to bit `idx` of that layer's buffer.
- Threshold edge cases:
  - `t_data`=0: the neuron always fires.
  - `t_data` 9..15: the neuron never fires. No saturation or wrap.
- Layer transition: at `idx`=N-1, `idx` resets to 0 and the state advances.
- Completion, on the last L3 edge:
  - `result` <= {fire, `l3`[2:0]}; `l2_hi` <= `l2`[7:4].
  - `done` <= 1, `busy` <= 0, state → IDLE.
- `result` and `l2_hi` hold until the next completion. They do not change during a run.
- `done` clears on every edge other than a completion edge, including edges with `ena`=0.
- `ena`=0 mid-run:
  - State, `idx`, buffers and `w_addr` freeze.
  - The run resumes unchanged when `ena` returns.
- Bank writes during a run: the bank owner must not write while `busy`=1. If it does, only neurons not yet evaluated see the new value. No error is flagged.
- Reset, including mid-run:
  - State → IDLE; `idx`, `x_reg`, `l1`, `l2`, `l3` = 0.
  - `busy`=0, `done`=0, `result`=0, `l2_hi`=0, `w_addr`=0.
  - The partial run is discarded.

## Timing
- Edge E0 accepts `start`. E1..E8 write L1, E9..E16 write L2, E17..E20 write L3 (assuming `ena`=1 throughout).
- `busy` is high in the cycles after E0 through E19 (20 cycles). It is low after E20.
- `done`, `result` and `l2_hi` change at E20. `done` is high for exactly one cycle.
- A `start` at E20 is ignored. The earliest next accept is E21, so the back-to-back period is 21 cycles.
- `w_addr` is registered:
  - Value k is stable for the whole cycle preceding the edge that evaluates neuron k.
  - In IDLE it is 0.
- Every `ena`=0 cycle adds exactly one cycle of latency.

## Test plan
- All 20 weights 0x00, thresholds 0; `start` with `in_vec`=0x5A → `done` 20 cycles later, `result`=0xF, `l2_hi`=0xF, `busy` high exactly 20 cycles.
- All weights 0xFF, thresholds 8:
  - `in_vec`=0xFF → `result`=0xF, `l2_hi`=0xF.
  - Rerun with 0xFE → L1=0x00, L2=0x00, `result`=0x0, `l2_hi`=0x0.
- Bank preloaded with the team default weight set (`weights[0..19]` = 7B,8B,D1,00,14,4D,8F,03, E1,97,E1,B5,44,9B,8E,58, DF,47,D6,42), thresholds all 4, `in_vec`=0x00 → L1=0xBE, L2=0x6A, `result`=0xA, `l2_hi`=0x6. Check `w_addr` steps 0..19, one per cycle.
- `start` held high continuously → accepts at E0 and E21 only. `done` pulses at E20 and E41. `start` is not re-accepted while busy.
- `ena` low for 3 cycles in mid-L2, and `reset` pulsed at E12 of a second run:
  - The first run completes at E23 with an unchanged `result`.
  - The reset clears all outputs to 0 asynchronously.
  - The next `start` runs cleanly in 20 cycles.
- Thresholds 9 on L3 neurons, all other values 0 → `result`=0x0 regardless of `in_vec`. Threshold 0 on L3 → `result`=0xF.
